// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: prescaled, mode-selectable pulse generator with burst/continuous runs.
//
// A prescaler divides clk down to a base tick. The latched 2-bit mode picks one of four
// periods (in ticks). Each period starts with a PW-tick high pulse. A run is launched on a
// rising edge of start and aborted whenever start is low. A non-zero burst stops the run
// after that many periods and raises a sticky done flag.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        level enable; rising edge launches a run, low aborts it
//   mode         period select, latched at launch
//   burst        pulse count, latched at launch; 0 = continuous
//   pulse        registered pulse output
//   busy         high while running
//   done         sticky burst-complete flag
//   pulses_sent  completed periods in the current/last run
module pulse_gen_multi #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned P0       = 1000,
    parameter int unsigned P1       = 500,
    parameter int unsigned P2       = 250,
    parameter int unsigned P3       = 100,
    parameter int unsigned PW       = 1,
    parameter int unsigned PER_W    = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic             start_d;
    logic [1:0]       mode_l;
    logic [CNT_W-1:0] burst_l;
    logic [DIV_W-1:0] presc;
    logic [PER_W-1:0] tcnt;

    logic             start_edge;
    logic             tick;
    logic             wrap;
    logic [PER_W-1:0] period_last;
    logic [PER_W-1:0] tcnt_next;
    logic [CNT_W-1:0] sent_next;
    logic             burst_end;

    assign start_edge = start & ~start_d;
    assign tick       = (presc == DIV_W'(TICK_DIV - 1));

    always_comb begin
        period_last = PER_W'(P0 - 1);
        unique case (mode_l)
            2'b00:   period_last = PER_W'(P0 - 1);
            2'b01:   period_last = PER_W'(P1 - 1);
            2'b10:   period_last = PER_W'(P2 - 1);
            2'b11:   period_last = PER_W'(P3 - 1);
            default: period_last = PER_W'(P0 - 1);
        endcase
    end

    // wrap marks the last clock of a period
    assign wrap      = tick && (tcnt == period_last);
    assign tcnt_next = wrap ? '0 : (tick ? tcnt + PER_W'(1) : tcnt);
    assign sent_next = pulses_sent + CNT_W'(1);
    assign burst_end = wrap && (burst_l != '0) && (sent_next == burst_l);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            start_d     <= 1'b0;
            mode_l      <= 2'b00;
            burst_l     <= '0;
            presc       <= '0;
            tcnt        <= '0;
            pulse       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else begin
            start_d <= start;
            case (state)
                StIdle, StDone: begin
                    if (start_edge) begin
                        state       <= StRun;
                        mode_l      <= mode;
                        burst_l     <= burst;
                        presc       <= '0;
                        tcnt        <= '0;
                        pulses_sent <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        // tick counter restarts at 0, which is inside the high window
                        pulse       <= 1'b1;
                    end
                end
                StRun: begin
                    if (!start) begin
                        // abort wins over a coincident wrap; pulses_sent keeps its value
                        state <= StIdle;
                        pulse <= 1'b0;
                        busy  <= 1'b0;
                    end else if (burst_end) begin
                        state       <= StDone;
                        pulse       <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pulses_sent <= sent_next;
                    end else begin
                        presc <= tick ? '0 : presc + DIV_W'(1);
                        tcnt  <= tcnt_next;
                        pulse <= (tcnt_next < PER_W'(PW));
                        if (wrap) begin
                            pulses_sent <= sent_next;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
